// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: OAM DMA bus initiator. Copies LEN bytes from page {src_page,8'h00}
// to DST_BASE at one byte per cycle. The read port is combinational and the
// write port is synchronous, so each byte passes through a one-deep write stage
// and reads overlap writes 1:1.
//
// Optional build macro: OAM_DMA_ECHO_FOLD_EN
//   defined   : source pages 8'hE0..8'hFF are folded down by 8'h20 (echo RAM -> WRAM)
//   undefined : source page is used verbatim
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start, not busy
// ST_DELAY | START_DELAY idle cycles before the first read, no memory access
// ST_XFER  | reading byte idx; previous byte is in the write stage
// ST_DRAIN | last byte is being written; done pulses on the following cycle

module oam_dma_ctrl #(
  parameter int unsigned LEN         = 160,
  parameter logic [15:0] DST_BASE    = 16'hFE00,
  parameter int unsigned START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  src_page,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_r_addr,
  input  logic [7:0]  mem_r_data,
  output logic [15:0] mem_w_addr,
  output logic [7:0]  mem_w_data,
  output logic        mem_wen
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);
  localparam logic [3:0] DLY_INIT = 4'(START_DELAY);

  state_t     state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic [3:0] dly_q, dly_d;
  logic [7:0] data_q, data_d;
  logic [7:0] w_idx_q, w_idx_d;
  logic       wvalid_q, wvalid_d;
  logic       done_q, done_d;

  // Page actually read from; echo folding only exists in the macro build.
  function automatic logic [7:0] fold_page(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_FOLD_EN
    return (p >= 8'hE0) ? (p - 8'h20) : p;
`else
    return p;
`endif
  endfunction

  // State register and write-stage flops; reset drops mem_wen immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      src_q    <= 8'h00;
      idx_q    <= 8'h00;
      dly_q    <= 4'h0;
      data_q   <= 8'h00;
      w_idx_q  <= 8'h00;
      wvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      idx_q    <= idx_d;
      dly_q    <= dly_d;
      data_q   <= data_d;
      w_idx_q  <= w_idx_d;
      wvalid_q <= wvalid_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: sequencing, write-stage capture and start/restart handling.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    idx_d    = idx_q;
    dly_d    = dly_q;
    data_d   = data_q;
    w_idx_d  = w_idx_q;
    wvalid_d = 1'b0;
    done_d   = 1'b0;

    // The write stage loads on every read cycle, even one cut short by a
    // restart, so a byte already read is never silently dropped.
    if (state_q == ST_XFER) begin
      data_d   = mem_r_data;
      w_idx_d  = idx_q;
      wvalid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
      end
      ST_DELAY: begin
        if (dly_q <= 4'd1) begin
          state_d = ST_XFER;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      ST_XFER: begin
        idx_d = idx_q + 8'd1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Start wins in every state; in DRAIN the completion pulse is kept.
    if (start) begin
      src_d   = fold_page(src_page);
      idx_d   = 8'h00;
      dly_d   = DLY_INIT;
      state_d = (DLY_INIT != 4'd0) ? ST_DELAY : ST_XFER;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign mem_r_addr = {src_q, idx_q};
  assign mem_wen    = wvalid_q;
  assign mem_w_addr = DST_BASE + {8'h00, w_idx_q};
  assign mem_w_data = data_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  localparam int LEN_A = 160;
  localparam int SD_A  = 1;
  localparam int LEN_B = 4;
  localparam int SD_B  = 0;
  localparam logic [15:0] DST = 16'hFE00;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [7:0]  src_a, src_b;
  logic        busy_a, busy_b, done_a, done_b, wen_a, wen_b;
  logic [15:0] r_addr_a, r_addr_b, w_addr_a, w_addr_b;
  logic [7:0]  r_data_a, r_data_b, w_data_a, w_data_b;

  logic [7:0]  mem_a [65536];
  logic [7:0]  mem_b [65536];
  logic        loaded = 1'b0;

  logic [23:0] wlog_a [$];
  logic [23:0] wlog_b [$];
  int          done_cnt_a = 0;
  int          done_cnt_b = 0;

  int vectors = 0;
  int errors  = 0;

  oam_dma_ctrl u_a (
    .clk(clk), .rst(rst), .start(start_a), .src_page(src_a),
    .busy(busy_a), .done(done_a),
    .mem_r_addr(r_addr_a), .mem_r_data(r_data_a),
    .mem_w_addr(w_addr_a), .mem_w_data(w_data_a), .mem_wen(wen_a)
  );

  oam_dma_ctrl #(.LEN(LEN_B), .DST_BASE(DST), .START_DELAY(SD_B)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .src_page(src_b),
    .busy(busy_b), .done(done_b),
    .mem_r_addr(r_addr_b), .mem_r_data(r_data_b),
    .mem_w_addr(w_addr_b), .mem_w_data(w_data_b), .mem_wen(wen_b)
  );

  always #5 clk = ~clk;

  // Reference memory content before any DMA write.
  function automatic logic [7:0] pre(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC0);
  endfunction

  // Page the engine is expected to read from.
  function automatic logic [7:0] fold_model(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_FOLD_EN
    if (p >= 8'hE0) return p - 8'h20;
`endif
    return p;
  endfunction

  // Test memories: combinational read, synchronous write, preloaded on the first edge.
  assign r_data_a = mem_a[r_addr_a];
  assign r_data_b = mem_b[r_addr_b];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int a = 0; a < 65536; a++) begin
        mem_a[a] = pre(16'(a));
        mem_b[a] = pre(16'(a));
      end
      loaded = 1'b1;
    end else begin
      if (wen_a) mem_a[w_addr_a] = w_data_a;
      if (wen_b) mem_b[w_addr_b] = w_data_b;
    end
  end

  // Write/done monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (wen_a === 1'b1) wlog_a.push_back({w_addr_a, w_data_a});
    if (wen_b === 1'b1) wlog_b.push_back({w_addr_b, w_data_b});
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1);
  end

  function automatic int len_of(input int d);  return (d == 0) ? LEN_A : LEN_B; endfunction
  function automatic int sd_of(input int d);   return (d == 0) ? SD_A : SD_B; endfunction
  function automatic logic busy_of(input int d); return (d == 0) ? busy_a : busy_b; endfunction
  function automatic logic done_of(input int d); return (d == 0) ? done_a : done_b; endfunction
  function automatic logic wen_of(input int d);  return (d == 0) ? wen_a : wen_b; endfunction
  function automatic logic [15:0] raddr_of(input int d); return (d == 0) ? r_addr_a : r_addr_b; endfunction
  function automatic logic [15:0] waddr_of(input int d); return (d == 0) ? w_addr_a : w_addr_b; endfunction
  function automatic logic [7:0]  wdata_of(input int d); return (d == 0) ? w_data_a : w_data_b; endfunction
  function automatic int log_size(input int d); return (d == 0) ? wlog_a.size() : wlog_b.size(); endfunction
  function automatic int dcnt(input int d); return (d == 0) ? done_cnt_a : done_cnt_b; endfunction
  function automatic logic [7:0] mem_of(input int d, input logic [15:0] a);
    return (d == 0) ? mem_a[a] : mem_b[a];
  endfunction
  function automatic logic [23:0] log_at(input int d, input int i);
    if (i >= log_size(d)) return 24'hxxxxxx;
    return (d == 0) ? wlog_a[i] : wlog_b[i];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic s, input logic [7:0] p);
    if (d == 0) begin start_a = s; src_a = p; end
    else        begin start_b = s; src_b = p; end
  endtask

  // Compare LEN consecutive log entries against the copy of page ep.
  task automatic check_copy(input int d, input int first, input logic [7:0] ep, input string tag);
    logic [23:0] exp;
    logic [23:0] got;
    for (int k = 0; k < len_of(d); k++) begin
      exp = {DST + 16'(k), pre({ep, 8'(k)})};
      got = log_at(d, first + k);
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s d=%0d byte=%0d got=%h want=%h", tag, d, k, got, exp);
      end
    end
  endtask

  // Check the busy/done profile for lat edges after an accepted start.
  task automatic check_profile(input int d, input int lat, input string tag);
    for (int n = 1; n <= lat; n++) begin
      tick();
      vectors++;
      if (busy_of(d) !== (n < lat) || done_of(d) !== (n == lat)) begin
        errors++;
        $display("FAIL %s d=%0d edge=%0d got busy=%b done=%b want busy=%b done=%b",
                 tag, d, n, busy_of(d), done_of(d), (n < lat), (n == lat));
      end
    end
    tick();
    vectors++;
    if (done_of(d) !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_width d=%0d got=%b want=0", tag, d, done_of(d));
    end
  endtask

  task automatic run_xfer(input int d, input logic [7:0] page, input string tag);
    int l0, dc0, lat;
    lat = sd_of(d) + len_of(d) + 1;
    drive(d, 1'b1, page);
    tick();
    drive(d, 1'b0, 8'($urandom));
    l0  = log_size(d);
    dc0 = dcnt(d);
    vectors++;
    if (busy_of(d) !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_start d=%0d got=%b want=1", tag, d, busy_of(d));
    end
    check_profile(d, lat, tag);
    vectors++;
    if (log_size(d) - l0 !== len_of(d)) begin
      errors++;
      $display("FAIL %s_wen_cycles d=%0d got=%0d want=%0d", tag, d, log_size(d) - l0, len_of(d));
    end
    vectors++;
    if (dcnt(d) - dc0 !== 1) begin
      errors++;
      $display("FAIL %s_done_count d=%0d got=%0d want=1", tag, d, dcnt(d) - dc0);
    end
    check_copy(d, l0, fold_model(page), tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      vectors++; if (busy_of(d) !== 1'b0) begin errors++; $display("FAIL rst_busy d=%0d got=%b want=0", d, busy_of(d)); end
      vectors++; if (done_of(d) !== 1'b0) begin errors++; $display("FAIL rst_done d=%0d got=%b want=0", d, done_of(d)); end
      vectors++; if (wen_of(d) !== 1'b0)  begin errors++; $display("FAIL rst_wen d=%0d got=%b want=0", d, wen_of(d)); end
      vectors++; if (raddr_of(d) !== 16'h0000) begin errors++; $display("FAIL rst_raddr d=%0d got=%h want=0000", d, raddr_of(d)); end
      vectors++; if (waddr_of(d) !== DST) begin errors++; $display("FAIL rst_waddr d=%0d got=%h want=%h", d, waddr_of(d), DST); end
      vectors++; if (wdata_of(d) !== 8'h00) begin errors++; $display("FAIL rst_wdata d=%0d got=%h want=00", d, wdata_of(d)); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_xfer(0, 8'hC0, "basic");
    for (int k = 0; k < LEN_A; k++) begin
      vectors++;
      if (mem_of(0, DST + 16'(k)) !== (8'(k) ^ 8'h5A)) begin
        errors++;
        $display("FAIL basic_mem addr=%h got=%h want=%h", DST + 16'(k), mem_of(0, DST + 16'(k)), 8'(k) ^ 8'h5A);
      end
    end
  endtask

  task automatic test_short();
    run_xfer(1, 8'h80, "short");
  endtask

  task automatic test_fold();
    run_xfer(0, 8'hE1, "fold");
    run_xfer(1, 8'hF3, "fold");
  endtask

  task automatic test_random();
    int d;
    repeat (8) begin
      d = int'($urandom_range(0, 1));
      run_xfer(d, 8'($urandom_range(0, 253)), "random");
    end
  endtask

  task automatic test_restart(input int k, input logic [7:0] p1, input logic [7:0] p2);
    int l0, dc0, lat;
    logic [7:0] e1, e2;
    lat = SD_A + LEN_A + 1;
    e1 = fold_model(p1);
    e2 = fold_model(p2);
    drive(0, 1'b1, p1);
    tick();
    drive(0, 1'b0, 8'h00);
    l0  = log_size(0);
    dc0 = dcnt(0);
    repeat (SD_A + k) tick();
    vectors++;
    if (r_addr_a !== {e1, 8'(k)}) begin
      errors++;
      $display("FAIL restart_raddr got=%h want=%h", r_addr_a, {e1, 8'(k)});
    end
    drive(0, 1'b1, p2);
    tick();
    drive(0, 1'b0, 8'h00);
    check_profile(0, lat, "restart");
    vectors++;
    if (dcnt(0) - dc0 !== 1) begin
      errors++;
      $display("FAIL restart_done_count got=%0d want=1", dcnt(0) - dc0);
    end
    for (int j = 0; j < k; j++) begin
      vectors++;
      if (log_at(0, l0 + j) !== {DST + 16'(j), pre({e1, 8'(j)})}) begin
        errors++;
        $display("FAIL restart_prefix byte=%0d got=%h want=%h", j, log_at(0, l0 + j), {DST + 16'(j), pre({e1, 8'(j)})});
      end
    end
    check_copy(0, log_size(0) - LEN_A, e2, "restart_tail");
    for (int j = 0; j < LEN_A; j++) begin
      vectors++;
      if (mem_a[DST + 16'(j)] !== pre({e2, 8'(j)})) begin
        errors++;
        $display("FAIL restart_mem addr=%h got=%h want=%h", DST + 16'(j), mem_a[DST + 16'(j)], pre({e2, 8'(j)}));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] snap [LEN_A];
    int dc0;
    for (int k = 0; k < LEN_A; k++) snap[k] = mem_a[DST + 16'(k)];
    drive(0, 1'b1, 8'hC0);
    tick();
    drive(0, 1'b0, 8'h00);
    dc0 = done_cnt_a;
    repeat (SD_A + 10) tick();
    vectors++;
    if (r_addr_a !== 16'hC00A) begin
      errors++;
      $display("FAIL rstmid_raddr got=%h want=c00a", r_addr_a);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (wen_a !== 1'b0) begin errors++; $display("FAIL rstmid_wen got=%b want=0", wen_a); end
    vectors++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy_a); end
    repeat (3) tick();
    rst = 1'b0;
    repeat (200) tick();
    vectors++;
    if (done_cnt_a !== dc0) begin errors++; $display("FAIL rstmid_done got=%0d want=%0d", done_cnt_a - dc0, 0); end
    vectors++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got=%b want=0", busy_a); end
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (mem_a[DST + 16'(k)] !== pre({8'hC0, 8'(k)})) begin
        errors++;
        $display("FAIL rstmid_head addr=%h got=%h want=%h", DST + 16'(k), mem_a[DST + 16'(k)], pre({8'hC0, 8'(k)}));
      end
    end
    for (int k = 10; k < LEN_A; k++) begin
      vectors++;
      if (mem_a[DST + 16'(k)] !== snap[k]) begin
        errors++;
        $display("FAIL rstmid_tail addr=%h got=%h want=%h", DST + 16'(k), mem_a[DST + 16'(k)], snap[k]);
      end
    end
  endtask

  task automatic test_back_to_back(input int d, input logic [7:0] p1, input logic [7:0] p2);
    int l0, dc0, lat;
    lat = sd_of(d) + len_of(d) + 1;
    drive(d, 1'b1, p1);
    tick();
    drive(d, 1'b0, 8'h00);
    l0  = log_size(d);
    dc0 = dcnt(d);
    repeat (lat - 1) tick();
    drive(d, 1'b1, p2);
    tick();
    drive(d, 1'b0, 8'h00);
    vectors++;
    if (done_of(d) !== 1'b1 || busy_of(d) !== 1'b1) begin
      errors++;
      $display("FAIL b2b_handover d=%0d got done=%b busy=%b want done=1 busy=1", d, done_of(d), busy_of(d));
    end
    check_profile(d, lat, "b2b");
    vectors++;
    if (dcnt(d) - dc0 !== 2) begin
      errors++;
      $display("FAIL b2b_done_count d=%0d got=%0d want=2", d, dcnt(d) - dc0);
    end
    vectors++;
    if (log_size(d) - l0 !== 2 * len_of(d)) begin
      errors++;
      $display("FAIL b2b_wen_cycles d=%0d got=%0d want=%0d", d, log_size(d) - l0, 2 * len_of(d));
    end
    check_copy(d, l0, fold_model(p1), "b2b_first");
    check_copy(d, l0 + len_of(d), fold_model(p2), "b2b_second");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_fold();
    test_random();
    test_restart(50, 8'hC0, 8'hD0);
    test_restart(int'($urandom_range(1, 150)), 8'($urandom_range(0, 253)), 8'($urandom_range(0, 253)));
    test_reset_mid();
    test_back_to_back(0, 8'hC0, 8'h12);
    test_back_to_back(1, 8'($urandom_range(0, 253)), 8'($urandom_range(0, 253)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
